// File: rtl/voxel_pkg.sv
// Shared encodings for the voxel projector: view modes, FSM states and default colours.
package voxel_pkg;

    typedef logic [1:0] mode_t;
    typedef logic [1:0] state_t;

    localparam mode_t MODE_TOP   = 2'd0;
    localparam mode_t MODE_FRONT = 2'd1;
    localparam mode_t MODE_SIDE  = 2'd2;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SCAN  = 2'd1;
    localparam state_t WRITE = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam logic [7:0] FG_DEFAULT = 8'hFF;
    localparam logic [7:0] BG_DEFAULT = 8'h00;

endpackage

// File: rtl/voxel_mem.sv
// N*N*N x 1-bit voxel occupancy store: async clear, one write port, combinational read.
module voxel_mem #(
    parameter int N = 8,
    localparam int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [CW-1:0] wx,
    input  logic [CW-1:0] wy,
    input  logic [CW-1:0] wz,
    input  logic          wd,
    input  logic [CW-1:0] rx,
    input  logic [CW-1:0] ry,
    input  logic [CW-1:0] rz,
    output logic          rd
);

    // Flat bit vector indexed by {z, y, x}; N is a power of two so the concatenation is dense.
    logic [N*N*N-1:0] cells;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cells <= '0;
        end else if (we) begin
            cells[{wz, wy, wx}] <= wd;
        end
    end

    assign rd = cells[{rz, ry, rx}];

endmodule

// File: rtl/voxel_projector.sv
// Orthographic voxel projector: scans the voxel store per screen column and writes one
// pixel per column into the framebuffer during blanking. Optional: VOXEL_DEPTH_SHADE_EN.
module voxel_projector
    import voxel_pkg::*;
#(
    parameter int             N          = 8,
    parameter int             AW         = 12,
    parameter int             DW         = 8,
    parameter int             FB_STRIDE  = 16,
    parameter logic [DW-1:0]  FG_COLOR   = DW'(FG_DEFAULT),
    parameter logic [DW-1:0]  BG_COLOR   = DW'(BG_DEFAULT),
    parameter logic [DW-1:0]  SHADE_STEP = DW'(8'h10),
    localparam int            CW         = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] fb_base,
    input  logic          display_on,
    input  logic          vox_we,
    input  logic [CW-1:0] vox_x,
    input  logic [CW-1:0] vox_y,
    input  logic [CW-1:0] vox_z,
    input  logic          vox_d,
    output logic          busy,
    output logic          done,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] ram_d
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    mode_t         mode_q;
    logic [AW-1:0] base_q;
    logic [CW-1:0] u;
    logic [CW-1:0] v;
    logic [CW-1:0] d;
    logic [DW-1:0] colour;

    logic [CW-1:0] rx;
    logic [CW-1:0] ry;
    logic [CW-1:0] rz;
    logic          occupied;
    logic [DW-1:0] hit_colour;
    logic [AW-1:0] pix_addr;

    // Writes are blocked for the whole pass so the scan sees a stable snapshot.
    voxel_mem #(
        .N (N)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (vox_we & ~busy),
        .wx    (vox_x),
        .wy    (vox_y),
        .wz    (vox_z),
        .wd    (vox_d),
        .rx    (rx),
        .ry    (ry),
        .rz    (rz),
        .rd    (occupied)
    );

    always_comb begin
        rx = u;
        ry = v;
        rz = d;
        case (mode_q)
            MODE_FRONT: begin
                rx = u;
                ry = d;
                rz = v;
            end
            MODE_SIDE: begin
                rx = d;
                ry = u;
                rz = v;
            end
            default: begin
                rx = u;
                ry = v;
                rz = d;
            end
        endcase
    end

`ifdef VOXEL_DEPTH_SHADE_EN
    logic [DW+CW-1:0] drop;

    // Saturate at 1 so a far hit never reads back as the empty-column colour.
    always_comb begin
        drop = (DW+CW)'(d) * (DW+CW)'(SHADE_STEP);
        if (drop >= (DW+CW)'(FG_COLOR)) begin
            hit_colour = DW'(1);
        end else begin
            hit_colour = FG_COLOR - DW'(drop);
        end
    end
`else
    assign hit_colour = FG_COLOR;
`endif

    assign pix_addr = base_q + AW'(v) * AW'(FB_STRIDE) + AW'(u);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            we     <= 1'b0;
            addr   <= '0;
            ram_d  <= '0;
            mode_q <= MODE_TOP;
            base_q <= '0;
            u      <= '0;
            v      <= '0;
            d      <= '0;
            colour <= '0;
        end else begin
            done <= 1'b0;
            we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        base_q <= fb_base;
                        u      <= '0;
                        v      <= '0;
                        d      <= '0;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (occupied) begin
                        colour <= hit_colour;
                        state  <= WRITE;
                    end else if (d == LAST) begin
                        colour <= BG_COLOR;
                        state  <= WRITE;
                    end else begin
                        d <= d + CW'(1);
                    end
                end
                WRITE: begin
                    if (!display_on) begin
                        we    <= 1'b1;
                        addr  <= pix_addr;
                        ram_d <= colour;
                        d     <= '0;
                        if (u == LAST) begin
                            u <= '0;
                            if (v == LAST) begin
                                state <= DONE;
                            end else begin
                                v     <= v + CW'(1);
                                state <= SCAN;
                            end
                        end else begin
                            u     <= u + CW'(1);
                            state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
